// File: rtl/v_bus_pkg.sv
// Shared types and constants for the register-bank bus sequencer.
// Holds the sequencer state encoding, R_W polarity and default sizes.
package v_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Register bank R_W polarity: high holds, low loads at the next edge.
    localparam logic RW_HOLD = 1'b1;
    localparam logic RW_LOAD = 1'b0;

    localparam int DEF_W    = 16;
    localparam int DEF_NREG = 8;

    // True when a register index does not name an existing register.
    function automatic logic idx_bad(input int idx, input int n);
        return idx >= n;
    endfunction

endpackage

// File: rtl/v_onehot_dec.sv
// Index to one-hot decoder with enable; indices >= NREG decode to zero.
// Ports: en (enable), idx [AW-1:0] (index), onehot [NREG-1:0] (result).
module v_onehot_dec
    import v_bus_pkg::*;
#(
    parameter int AW   = 4,
    parameter int NREG = DEF_NREG
) (
    input  logic            en,
    input  logic [AW-1:0]   idx,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREG; i++) begin
            if (en && (idx == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/v_bus_xfer_ctrl.sv
// Bus-master sequencer moving data between bank registers or from an
// immediate into a register, one transfer per valid/ready handshake.
// Ports: CLK, CLR (sync, active-high); request side REQ_V/REQ_RDY,
// REQ_SRC, REQ_DST, REQ_IMM, REQ_DATA; bank side EA (one-hot read
// enable), R_W (low = load), BUS_IN (read bus), BUS_OUT (write bus);
// status DONE and ERR pulses, XDATA (last value written).
// Option: V_BUS_XFER_CTRL_B2B_EN also accepts requests in FIN so
// transfers can run back to back.
module v_bus_xfer_ctrl
    import v_bus_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int W    = DEF_W,
    parameter int AW   = 4
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            REQ_V,
    output logic            REQ_RDY,
    input  logic [AW-1:0]   REQ_SRC,
    input  logic [AW-1:0]   REQ_DST,
    input  logic            REQ_IMM,
    input  logic [W-1:0]    REQ_DATA,
    output logic [NREG-1:0] EA,
    output logic [NREG-1:0] R_W,
    input  logic [W-1:0]    BUS_IN,
    output logic [W-1:0]    BUS_OUT,
    output logic            DONE,
    output logic            ERR,
    output logic [W-1:0]    XDATA
);

    state_t          state;
    logic [AW-1:0]   src;
    logic [AW-1:0]   dst;
    logic [W-1:0]    lat;
    logic [W-1:0]    xdata_q;
    logic            done_q;
    logic            err_q;
    logic            accept;
    logic            req_bad;
    logic            can_take;
    logic [NREG-1:0] ld_sel;

    // States in which a new request may be taken.
`ifdef V_BUS_XFER_CTRL_B2B_EN
    assign can_take = (state == IDLE) || (state == FIN);
`else
    assign can_take = (state == IDLE);
`endif

    // CLR gates ready directly so nothing is accepted on a reset edge.
    assign REQ_RDY = !CLR && can_take;
    assign accept  = REQ_V && REQ_RDY;

    // Source range only matters when the bus is actually read.
    assign req_bad = idx_bad(int'(REQ_DST), NREG) ||
                     (!REQ_IMM && idx_bad(int'(REQ_SRC), NREG));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            lat     <= '0;
            xdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                // An accept in FIN overrides the return to IDLE.
                src <= REQ_SRC;
                dst <= REQ_DST;
                if (req_bad) begin
                    err_q <= 1'b1;
                    state <= FIN;
                end else if (REQ_IMM) begin
                    lat   <= REQ_DATA;
                    state <= WRITE;
                end else begin
                    state <= READ;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    READ: begin
                        lat   <= BUS_IN;
                        state <= WRITE;
                    end
                    WRITE: begin
                        xdata_q <= lat;
                        done_q  <= 1'b1;
                        state   <= FIN;
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Bank strobes decode from registered state and indices only.
    v_onehot_dec #(
        .AW   (AW),
        .NREG (NREG)
    ) u_ea_dec (
        .en     (state == READ),
        .idx    (src),
        .onehot (EA)
    );

    v_onehot_dec #(
        .AW   (AW),
        .NREG (NREG)
    ) u_rw_dec (
        .en     (state == WRITE),
        .idx    (dst),
        .onehot (ld_sel)
    );

    always_comb begin
        R_W = '0;
        for (int i = 0; i < NREG; i++) begin
            R_W[i] = ld_sel[i] ? RW_LOAD : RW_HOLD;
        end
    end

    // The latch stays on the write bus so FIN still shows the value.
    assign BUS_OUT = lat;
    assign XDATA   = xdata_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

    a_ea_onehot : assert property (
        @(posedge CLK) disable iff (CLR) $onehot0(EA));
    a_rw_onehot : assert property (
        @(posedge CLK) disable iff (CLR) $onehot0(~R_W));
    a_no_overlap : assert property (
        @(posedge CLK) disable iff (CLR) !((|EA) && !(&R_W)));
    a_pulse_excl : assert property (
        @(posedge CLK) disable iff (CLR) !(DONE && ERR));

endmodule
